// File: rtl/lblock_axil_if.sv
// lblock_axil_if: AXI4-Lite bus between the PS/VIP master and the LBlock register file.
interface lblock_axil_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/lblock_axil_slave.sv
// lblock_axil_slave: AXI4-Lite register file that loads, launches and collects the LBlock 64/80 core.
module lblock_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic          S_AXI_ACLK,
    input  logic          S_AXI_ARESETN,
    lblock_axil_if.slave  s_axi,
    output logic          core_start,
    output logic [63:0]   core_pt,
    output logic [79:0]   core_key,
    input  logic          core_done,
    input  logic [63:0]   core_ct,
    output logic          irq
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;
    logic awready_q, bvalid_q, arready_q, rvalid_q, start_q, ie_q, done_q;
    logic [DW-1:0] rdata_q, rdata_d, din_lo_q, din_hi_q, key0_q, key1_q, dout_lo_q, dout_hi_q, key2_m;
    logic [15:0] key2_q;
    logic [3:0] aw_idx, ar_idx_q;
    logic busy, aw_take, ar_take, cfg_we, ctrl_we, start_go, w1c, fin;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [DW/8-1:0] strb);
        logic [DW-1:0] m;
        for (int i = 0; i < DW/8; i++) m[8*i +: 8] = strb[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return m;
    endfunction

    assign busy     = state_q == BUSY;
    assign aw_idx   = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign aw_take  = s_axi.awvalid & s_axi.wvalid & !bvalid_q & !awready_q;
    assign ar_take  = s_axi.arvalid & !rvalid_q & !arready_q;
    // operand registers are frozen while the core runs so its inputs stay stable
    assign cfg_we   = awready_q & !busy;
    assign ctrl_we  = awready_q & (aw_idx == 4'd5) & s_axi.wstrb[0];
    assign start_go = ctrl_we & s_axi.wdata[0] & !busy;
    assign w1c      = awready_q & (aw_idx == 4'd6) & s_axi.wstrb[0] & s_axi.wdata[1];
    assign fin      = busy & core_done;
    assign key2_m   = merge(DW'(key2_q), s_axi.wdata, s_axi.wstrb);

    always_comb state_d = start_go ? BUSY : fin ? IDLE : state_q;

    always_ff @(posedge S_AXI_ACLK) state_q <= !S_AXI_ARESETN ? IDLE : state_d;

    always_comb begin
        case (ar_idx_q)
            4'd0:    rdata_d = din_lo_q;
            4'd1:    rdata_d = din_hi_q;
            4'd2:    rdata_d = key0_q;
            4'd3:    rdata_d = key1_q;
            4'd4:    rdata_d = DW'(key2_q);
            4'd5:    rdata_d = DW'({ie_q, 1'b0});
            4'd6:    rdata_d = DW'({done_q, busy});
            4'd7:    rdata_d = dout_lo_q;
            4'd8:    rdata_d = dout_hi_q;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            ar_idx_q  <= '0;
            start_q   <= 1'b0;
            ie_q      <= 1'b0;
            done_q    <= 1'b0;
            din_lo_q  <= '0;
            din_hi_q  <= '0;
            key0_q    <= '0;
            key1_q    <= '0;
            key2_q    <= '0;
            dout_lo_q <= '0;
            dout_hi_q <= '0;
        end else begin
            awready_q <= aw_take;
            bvalid_q  <= awready_q | (bvalid_q & !s_axi.bready);
            arready_q <= ar_take;
            if (ar_take) ar_idx_q <= s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
            if (arready_q) rdata_q <= rdata_d;
            rvalid_q  <= arready_q | (rvalid_q & !s_axi.rready);
            start_q   <= start_go;
            if (cfg_we && aw_idx == 4'd0) din_lo_q <= merge(din_lo_q, s_axi.wdata, s_axi.wstrb);
            if (cfg_we && aw_idx == 4'd1) din_hi_q <= merge(din_hi_q, s_axi.wdata, s_axi.wstrb);
            if (cfg_we && aw_idx == 4'd2) key0_q <= merge(key0_q, s_axi.wdata, s_axi.wstrb);
            if (cfg_we && aw_idx == 4'd3) key1_q <= merge(key1_q, s_axi.wdata, s_axi.wstrb);
            if (cfg_we && aw_idx == 4'd4) key2_q <= key2_m[15:0];
            if (ctrl_we) ie_q <= s_axi.wdata[1];
            // completion wins over a same-cycle W1C so no finished result is lost
            done_q <= fin | (done_q & !start_go & !w1c);
            if (fin) dout_lo_q <= core_ct[31:0];
            if (fin) dout_hi_q <= core_ct[63:32];
        end
    end

    logic unused;
    assign unused = &{1'b0, s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0], key2_m[DW-1:16]};

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = awready_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;
    assign s_axi.rvalid  = rvalid_q;
    assign core_start    = start_q;
    assign core_pt       = {din_hi_q, din_lo_q};
    assign core_key      = {key2_q, key1_q, key0_q};
    assign irq           = done_q & ie_q;
endmodule

// File: tb/tb_lblock_axil_slave.sv
// tb_lblock_axil_slave: directed AXI4-Lite bench with a 32-cycle stub LBlock core.
module tb_lblock_axil_slave;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic core_start, irq;
    logic core_done = 1'b0;
    logic core_run = 1'b0;
    logic [63:0] core_pt;
    logic [63:0] core_ct = '0;
    logic [63:0] ct_val = '0;
    logic [79:0] core_key;
    logic [31:0] rd;
    int core_cnt = 0;
    int starts = 0;
    int n_tests = 0;
    int n_fail = 0;
    int n;

    lblock_axil_if bus ();

    lblock_axil_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn), .s_axi(bus),
        .core_start(core_start), .core_pt(core_pt), .core_key(core_key),
        .core_done(core_done), .core_ct(core_ct), .irq(irq)
    );

    always #5 clk = ~clk;

    // stub core: ignores ARESETN, so a reset mid-op still sees a late done pulse
    always @(posedge clk) begin
        core_done <= 1'b0;
        core_ct   <= 64'hDEAD_BEEF_DEAD_BEEF;
        if (core_start) begin
            starts   <= starts + 1;
            core_run <= 1'b1;
            core_cnt <= 0;
        end else if (core_run) begin
            core_cnt <= core_cnt + 1;
            if (core_cnt == 31) begin
                core_done <= 1'b1;
                core_ct   <= ct_val;
                core_run  <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_lead, input int bwait);
        int k;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.awvalid = 1'b1;
        if (aw_lead > 0) begin
            repeat (aw_lead) tick();
            chk("aw_alone_waits", {bus.awready, bus.wready, bus.bvalid}, 3'b000);
        end
        bus.wvalid = 1'b1;
        k = 0;
        while (!bus.awready && k < 20) begin tick(); k++; end
        chk("aw_w_ready", {bus.awready, bus.wready}, 2'b11);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("b_after_hs", {bus.awready, bus.bvalid}, 2'b01);
        chk("bresp", bus.bresp, 2'b00);
        if (bwait > 0) begin
            repeat (bwait) tick();
            chk("bvalid_hold", {bus.bvalid, bus.awready}, 2'b10);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("bvalid_drop", bus.bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [5:0] a, input int rwait, output logic [31:0] d);
        int k;
        bus.araddr = a; bus.arvalid = 1'b1;
        k = 0;
        while (!bus.arready && k < 20) begin tick(); k++; end
        chk("arready", bus.arready, 1'b1);
        tick();
        bus.arvalid = 1'b0;
        chk("r_after_hs", {bus.arready, bus.rvalid}, 2'b01);
        chk("rresp", bus.rresp, 2'b00);
        d = bus.rdata;
        if (rwait > 0) begin
            repeat (rwait) tick();
            chk("rdata_hold", {bus.rvalid, bus.rdata}, {1'b1, d});
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk("rvalid_drop", bus.rvalid, 1'b0);
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp, input int rwait);
        logic [31:0] v;
        axi_read(a, rwait, v);
        chk(tag, v, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arprot = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        repeat (3) tick();
        chk("rst_handshake", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 5'b0);
        chk("rst_core", {core_start, irq}, 2'b00);
        chk("rst_pt_key", {core_pt, core_key[15:0]}, 80'h0);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) axi_write(6'(4 * i), 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) rd_chk("plain_rw", 6'(4 * i), 32'(i + 1), 0);

        axi_write(6'h00, 32'h11223344, 4'hF, 0, 0);
        axi_write(6'h00, 32'hAABBCCDD, 4'b0010, 0, 0);
        rd_chk("wstrb_byte1", 6'h00, 32'h1122CC44, 0);

        axi_write(6'h3C, 32'hFFFFFFFF, 4'hF, 0, 0);
        rd_chk("unmapped", 6'h3C, 32'h0, 0);

        ct_val = 64'h4B7179D8_EBEE0C26;
        axi_write(6'h00, 32'h89ABCDEF, 4'hF, 0, 0);
        axi_write(6'h04, 32'h01234567, 4'hF, 0, 0);
        axi_write(6'h08, 32'h01234567, 4'hF, 0, 0);
        axi_write(6'h0C, 32'h89ABCDEF, 4'hF, 0, 0);
        axi_write(6'h10, 32'h1234FEDC, 4'hF, 0, 0);
        rd_chk("key2_upper_zero", 6'h10, 32'h0000FEDC, 0);
        chk("core_pt", core_pt, 64'h01234567_89ABCDEF);
        chk("core_key", core_key, 80'hFEDC_89ABCDEF_01234567);
        axi_write(6'h14, 32'h3, 4'hF, 0, 0);
        chk("one_start", starts, 1);
        rd_chk("status_busy", 6'h18, 32'h1, 0);
        rd_chk("ctrl_start_reads0", 6'h14, 32'h2, 0);

        axi_write(6'h14, 32'h3, 4'hF, 0, 0);
        axi_write(6'h00, 32'hFFFFFFFF, 4'hF, 0, 0);
        chk("no_restart", starts, 1);
        chk("pt_stable", core_pt, 64'h01234567_89ABCDEF);
        rd_chk("din_lo_kept", 6'h00, 32'h89ABCDEF, 0);

        n = 0;
        while (!core_done && n < 100) begin tick(); n++; end
        chk("core_done_seen", core_done, 1'b1);
        tick();
        chk("irq_set", irq, 1'b1);
        rd_chk("status_done", 6'h18, 32'h2, 0);
        rd_chk("dout_lo", 6'h1C, 32'hEBEE0C26, 0);
        rd_chk("dout_hi", 6'h20, 32'h4B7179D8, 0);
        chk("starts_total", starts, 1);

        axi_write(6'h18, 32'h2, 4'hF, 10, 0);
        rd_chk("status_w1c", 6'h18, 32'h0, 0);
        chk("irq_clear", irq, 1'b0);

        rd_chk("rd_backpressure", 6'h04, 32'h01234567, 5);
        axi_write(6'h08, 32'h01234567, 4'hF, 0, 5);

        ct_val = 64'h0123_4567_89AB_CDEF;
        axi_write(6'h14, 32'h3, 4'hF, 0, 0);
        chk("second_start", starts, 2);
        repeat (5) tick();
        rstn = 1'b0;
        tick();
        tick();
        chk("midrst_handshake", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 5'b0);
        chk("midrst_core", {core_start, irq}, 2'b00);
        chk("midrst_rdata_pt", {bus.rdata, core_pt[47:0]}, 80'h0);
        rstn = 1'b1;
        tick();
        rd_chk("status_after_rst", 6'h18, 32'h0, 0);
        n = 0;
        while (!core_done && n < 100) begin tick(); n++; end
        chk("late_done_seen", core_done, 1'b1);
        tick();
        rd_chk("late_done_dout", 6'h1C, 32'h0, 0);
        rd_chk("late_done_status", 6'h18, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
